// File: rtl/dark_channel_min3x3.sv
`timescale 1ns/1ps
// dark_channel_min3x3
// Streaming dark-channel estimator: per pixel min(R,G,B), then the minimum
// over a 3x3 window, with out-of-frame neighbours treated as 255.
// Raster-order in, raster-order out, one 8-bit value per input pixel.
//
// Ports
//   clock, reset_n    : single clock, asynchronous active-low reset
//   Enable, in_sof    : input pixel valid / first pixel of a frame
//   a, b, c           : R, G, B (unsigned 8-bit)
//   in_ready          : pixel can be taken this cycle (low while flushing)
//   out_valid/out_sof : output strobe / marks output pixel (0,0)
//   dataout           : dark-channel value
//
// Every accepted pixel or flush cycle is a "slot". Slot s carries the
// bottom-right neighbour of output pixel s-IMG_W-1, so that output is
// finished by that slot. Pipeline: stage 1 registers min(a,b,c) and a
// position tag, stage 2 forms the column minimum from the line buffers and
// shifts it into a 3-column window, stage 3 registers the window minimum.
module dark_channel_min3x3 #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       Enable,
  input  logic       in_sof,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] c,
  output logic       in_ready,
  output logic       out_valid,
  output logic       out_sof,
  output logic [7:0] dataout
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int FW = $clog2(IMG_W + 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  // Per-slot position facts, resolved once at slot time.
  typedef struct packed {
    logic lo_ok;   // row y-2 of the slot is inside the frame
    logic mid_ok;  // row y-1 of the slot is inside the frame
    logic emit;    // slot completes an output pixel
    logic sof;     // that output pixel is (0,0)
    logic lmask;   // output pixel sits in column 0
    logic rmask;   // output pixel sits in column IMG_W-1
  } tag_t;

  function automatic logic [7:0] min3(input logic [7:0] p, input logic [7:0] q,
                                      input logic [7:0] r);
    logic [7:0] t;
    t = (p < q) ? p : q;
    return (t < r) ? t : r;
  endfunction

  state_t          state;
  logic [XW-1:0]   xcnt;   // column of the next expected pixel
  logic [YW-1:0]   ycnt;   // line of the next expected pixel
  logic [FW-1:0]   fcnt;   // flush slot index 0..IMG_W

  logic            accept, start, restart, run_acc, fl_slot, last_fl, slot;
  logic [XW-1:0]   sx;
  logic [YW-1:0]   sy;
  logic [7:0]      sm;
  tag_t            stag;

  // vld_pipe[0]: stage 1 holds a slot, vld_pipe[1]: stage 2 holds a slot
  logic [1:0]      vld_pipe;
  logic [7:0]      s1_m;
  logic [XW-1:0]   s1_x;
  tag_t            s1_tag;
  logic            s2_emit, s2_sof, s2_lmask, s2_rmask;
  logic [2:0][7:0] cm;     // column minima, cm[2] newest
  logic [7:0]      lb1 [IMG_W];  // line y-1
  logic [7:0]      lb2 [IMG_W];  // line y-2
  logic [7:0]      up1, up2, colmin, win;

  // Slot generation and tagging
  always_comb begin
    accept   = Enable && in_ready;
    start    = accept && in_sof;
    restart  = start && (state == RUN);
    run_acc  = accept && !in_sof && (state == RUN);
    fl_slot  = (state == FLUSH);
    last_fl  = fl_slot && (fcnt == FW'(IMG_W));
    slot     = start || run_acc || fl_slot;
    sx       = '0;
    sy       = '0;
    sm       = 8'hFF;
    stag     = '0;
    if (fl_slot) begin
      // Flush row IMG_H, then one slot at (0, IMG_H+1) for the last pixel.
      sx          = last_fl ? '0 : fcnt[XW-1:0];
      stag.lo_ok  = 1'b1;
      stag.mid_ok = !last_fl;
      stag.emit   = 1'b1;
    end else begin
      if (!start) begin
        sx = xcnt;
        sy = ycnt;
      end
      sm          = min3(a, b, c);
      stag.mid_ok = (sy != '0);
      stag.lo_ok  = (sy != '0) && (sy != YW'(1));
      stag.emit   = stag.lo_ok || (stag.mid_ok && (sx != '0));
      stag.sof    = (sy == YW'(1)) && (sx == XW'(1));
    end
    // Slot in column 0 completes the previous line's last pixel.
    stag.lmask = (sx == XW'(1));
    stag.rmask = (sx == '0);
  end

  // Frame FSM
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      xcnt     <= '0;
      ycnt     <= '0;
      fcnt     <= '0;
      in_ready <= 1'b1;
    end else begin
      case (state)
        IDLE, RUN: begin
          if (start) begin
            state <= RUN;
            xcnt  <= XW'(1);
            ycnt  <= '0;
          end else if (run_acc) begin
            if (xcnt == XW'(IMG_W - 1)) begin
              xcnt <= '0;
              if (ycnt == YW'(IMG_H - 1)) begin
                state    <= FLUSH;
                in_ready <= 1'b0;
                fcnt     <= '0;
                ycnt     <= '0;
              end else begin
                ycnt <= ycnt + 1'b1;
              end
            end else begin
              xcnt <= xcnt + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (last_fl) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            fcnt     <= '0;
          end else begin
            fcnt <= fcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Column minimum; rows outside the frame read as 255.
  always_comb begin
    up1    = s1_tag.mid_ok ? lb1[s1_x] : 8'hFF;
    up2    = s1_tag.lo_ok  ? lb2[s1_x] : 8'hFF;
    colmin = min3(s1_m, up1, up2);
    win    = min3(cm[1], s2_lmask ? 8'hFF : cm[0], s2_rmask ? 8'hFF : cm[2]);
  end

  // Line buffers: contents before a line is written are masked by the tag.
  always_ff @(posedge clock) begin
    if (vld_pipe[0]) begin
      lb1[s1_x] <= s1_m;
      lb2[s1_x] <= lb1[s1_x];
    end
  end

  // A restart drops everything still in flight from the aborted frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe  <= '0;
      s1_m      <= '0;
      s1_x      <= '0;
      s1_tag    <= '0;
      s2_emit   <= 1'b0;
      s2_sof    <= 1'b0;
      s2_lmask  <= 1'b0;
      s2_rmask  <= 1'b0;
      cm        <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      dataout   <= '0;
    end else begin
      vld_pipe[0] <= slot;
      vld_pipe[1] <= vld_pipe[0] && !restart;
      if (slot) begin
        s1_m   <= sm;
        s1_x   <= sx;
        s1_tag <= stag;
      end
      if (vld_pipe[0]) begin
        cm       <= {colmin, cm[2], cm[1]};
        s2_emit  <= s1_tag.emit;
        s2_sof   <= s1_tag.sof;
        s2_lmask <= s1_tag.lmask;
        s2_rmask <= s1_tag.rmask;
      end
      out_valid <= vld_pipe[1] && s2_emit && !restart;
      out_sof   <= vld_pipe[1] && s2_emit && s2_sof && !restart;
      if (vld_pipe[1] && s2_emit && !restart) dataout <= win;
    end
  end

endmodule

// File: tb/tb_dark_channel_min3x3.sv
`timescale 1ns/1ps
// Self-checking bench for dark_channel_min3x3 at a 4x3 frame size.
// The model keeps the current frame's per-pixel channel minima and, for each
// slot that completes an output, computes the clipped 3x3 minimum and the
// edge on which it must appear.
module tb_dark_channel_min3x3;
  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       Enable  = 1'b0;
  logic       in_sof  = 1'b0;
  logic [7:0] a = '0, b = '0, c = '0;
  logic       in_ready, out_valid, out_sof;
  logic [7:0] dataout;

  dark_channel_min3x3 #(.IMG_W(W), .IMG_H(H)) dut (
    .clock(clock), .reset_n(reset_n), .Enable(Enable), .in_sof(in_sof),
    .a(a), .b(b), .c(c), .in_ready(in_ready), .out_valid(out_valid),
    .out_sof(out_sof), .dataout(dataout)
  );

  always #5 clock = ~clock;

  typedef struct { int due; logic [7:0] val; bit sof; } exp_t;
  exp_t       q[$];
  logic [7:0] got[$];
  logic [7:0] img [N];
  int checks = 0, errors = 0, cyc = 0, lowcnt = 0, sofcnt = 0, sidx = 0;
  bit active = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] min3(input logic [7:0] p, input logic [7:0] r,
                                      input logic [7:0] s);
    logic [7:0] m;
    m = p;
    if (r < m) m = r;
    if (s < m) m = s;
    return m;
  endfunction

  function automatic logic [7:0] ref_win(input int k);
    int x, y;
    logic [7:0] m;
    x = k % W;
    y = k / W;
    m = 8'hFF;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if (x + dx >= 0 && x + dx < W && y + dy >= 0 && y + dy < H)
          if (img[(y + dy) * W + x + dx] < m) m = img[(y + dy) * W + x + dx];
    return m;
  endfunction

  task automatic take_slot(input logic [7:0] v);
    exp_t e;
    if (sidx < N) img[sidx] = v;
    if (sidx >= W + 1) begin
      e.due = cyc + 2;
      e.val = ref_win(sidx - W - 1);
      e.sof = (sidx == W + 1);
      q.push_back(e);
    end
    sidx++;
    if (sidx == N + W + 1) active = 1'b0;
  endtask

  function automatic logic [23:0] pix(input int kind, input int k);
    case (kind)
      0: return {8'd200, 8'd100, 8'd150};
      1: return (k == W + 1) ? {8'd255, 8'd7, 8'd255} : 24'hFFFFFF;
      2: return (k == 0) ? 24'h000000 : 24'hFFFFFF;
      3: return {8'((k * 37 + 11) % 256), 8'((k * 53 + 200) % 256), 8'((k * 29 + 90) % 256)};
      4: return {8'd50, 8'd50, 8'd50};
      default: return 24'h000000;
    endcase
  endfunction

  task automatic send(input logic [23:0] p, input logic sof);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) chk("ready_timeout", int'(in_ready), 1);
    {a, b, c} = p;
    in_sof = sof;
    Enable = 1'b1;
    @(negedge clock);
    Enable = 1'b0;
    in_sof = 1'b0;
  endtask

  task automatic send_frame(input int kind, input int gap, input int count);
    for (int k = 0; k < count; k++) begin
      send(pix(kind, k), k == 0);
      repeat (gap) @(negedge clock);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() > 0 || !in_ready) && n < 300) begin
      @(negedge clock);
      n++;
    end
    chk("drain_pending", q.size(), 0);
    chk("drain_ready", int'(in_ready), 1);
    repeat (2) @(negedge clock);
  endtask

  initial begin
    int g0, l0, s0;
    logic [7:0] ref_run [N];
    fork
      begin : mon
        exp_t e;
        forever begin
          @(posedge clock);
          cyc++;
          if (!reset_n) begin
            q.delete();
            active = 1'b0;
          end else begin
            if (!in_ready) lowcnt++;
            if (in_ready && Enable && in_sof) begin
              if (active) q.delete();
              active = 1'b1;
              sidx = 0;
              take_slot(min3(a, b, c));
            end else if (in_ready && Enable && active) begin
              take_slot(min3(a, b, c));
            end else if (!in_ready && active) begin
              take_slot(8'hFF);
            end
          end
          #1;
          if (out_valid) begin
            if (q.size() == 0) begin
              chk("unexpected_out", int'(out_valid), 0);
            end else begin
              e = q.pop_front();
              chk("out_cycle", cyc, e.due);
              chk("out_value", int'(dataout), int'(e.val));
              chk("out_sof", int'(out_sof), int'(e.sof));
              got.push_back(dataout);
              if (out_sof) sofcnt++;
            end
          end else begin
            if (q.size() > 0 && q[0].due <= cyc) begin
              chk("missing_out", int'(out_valid), 1);
              void'(q.pop_front());
            end
            if (out_sof) chk("sof_without_valid", int'(out_sof), 0);
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sof", int'(out_sof), 0);
    chk("rst_dataout", int'(dataout), 0);
    reset_n = 1'b1;
    @(negedge clock);

    // Uniform frame
    g0 = got.size(); l0 = lowcnt; s0 = sofcnt;
    send_frame(0, 0, N);
    drain();
    chk("t1_count", got.size() - g0, N);
    for (int i = 0; i < N; i++) chk("t1_value", int'(got[g0 + i]), 100);
    chk("t1_ready_low_cycles", lowcnt - l0, 5);
    chk("t1_sof_count", sofcnt - s0, 1);

    // Single dark pixel at (1,1)
    g0 = got.size();
    send_frame(1, 0, N);
    drain();
    chk("t2_count", got.size() - g0, N);
    for (int i = 0; i < N; i++) chk("t2_value", int'(got[g0 + i]), (i % W == W - 1) ? 255 : 7);

    // Dark corner pixel: padding and no row wrap
    g0 = got.size();
    send_frame(2, 0, N);
    drain();
    chk("t3_count", got.size() - g0, N);
    for (int i = 0; i < N; i++)
      chk("t3_value", int'(got[g0 + i]), (i == 0 || i == 1 || i == W || i == W + 1) ? 0 : 255);

    // Gapless vs Enable pattern 1,0,0
    g0 = got.size();
    send_frame(3, 0, N);
    drain();
    chk("t4_count_gapless", got.size() - g0, N);
    for (int i = 0; i < N; i++) ref_run[i] = got[g0 + i];
    g0 = got.size();
    send_frame(3, 2, N);
    drain();
    chk("t4_count_gapped", got.size() - g0, N);
    for (int i = 0; i < N; i++) chk("t4_same_as_gapless", int'(got[g0 + i]), int'(ref_run[i]));

    // Restart at pixel (2,1) of frame A
    g0 = got.size(); s0 = sofcnt;
    send_frame(5, 0, W + 2);
    send_frame(4, 0, N);
    drain();
    chk("t5_count", got.size() - g0, N);
    for (int i = 0; i < N; i++) chk("t5_value", int'(got[g0 + i]), 50);
    chk("t5_sof_count", sofcnt - s0, 1);

    // Reset during flush, then a stray non-sof pixel, then a full frame
    send_frame(3, 0, N);
    @(negedge clock);
    chk("t6_flushing", int'(in_ready), 0);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_out_valid", int'(out_valid), 0);
    chk("t6_rst_out_sof", int'(out_sof), 0);
    chk("t6_rst_dataout", int'(dataout), 0);
    chk("t6_rst_in_ready", int'(in_ready), 1);
    g0 = got.size();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    send(pix(3, 5), 1'b0);
    repeat (4) @(negedge clock);
    chk("t6_no_output_idle", got.size() - g0, 0);
    s0 = sofcnt;
    send_frame(3, 1, N);
    drain();
    chk("t6_count", got.size() - g0, N);
    chk("t6_sof_count", sofcnt - s0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
